// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants and types for the PS/2 scan-code decoder.
//                Holds the two prefix byte values (extended, break) and the
//                prefix-tracking state enumeration.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GOT_E0   = 2'd1,
      GOT_F0   = 2'd2,
      GOT_E0F0 = 2'd3
   } ps2_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_rx
//  Description : PS/2 frame receiver. Synchronizes the raw keyboard clock and
//                data lines, detects ps2_clk falling edges, assembles the
//                11-bit frame (start, 8 data LSB first, odd parity, stop) and
//                checks parity/stop. A watchdog drops a partial frame when the
//                keyboard clock stalls.
//  Ports       : clk, reset       - system clock, synchronous active-high reset
//                i_ps2_clk        - raw keyboard clock (asynchronous)
//                i_ps2_data       - raw keyboard data  (asynchronous)
//                o_byte           - received data byte (valid with strobes)
//                o_byte_ok        - strobe: good frame completes this cycle
//                o_byte_err       - strobe: bad parity or stop bit this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_frame_rx #(
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_byte,
   output logic       o_byte_ok,
   output logic       o_byte_err
);

   localparam int                WDOG_W       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDOG_W-1:0] C_WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);
   localparam logic [WDOG_W-1:0] C_WDOG_ONE   = WDOG_W'(1);

   logic [1:0]        r_clk_sync;
   logic [1:0]        r_data_sync;
   logic              r_clk_prev;
   logic [3:0]        r_bit_cnt;
   logic [8:0]        r_shift;      // {parity, data[7:0]} once all 9 bits are in
   logic [WDOG_W-1:0] r_wdog;

   logic w_fall;
   logic w_data;
   logic w_last;
   logic w_frame_good;

   assign w_fall = r_clk_prev & ~r_clk_sync[1];
   assign w_data = r_data_sync[1];

   // Bit counter value 10 means start + 8 data + parity have been taken,
   // so the current edge carries the stop bit.
   assign w_last       = w_fall && (r_bit_cnt == 4'd10);
   assign w_frame_good = (^r_shift) & w_data;

   assign o_byte     = r_shift[7:0];
   assign o_byte_ok  = w_last &  w_frame_good;
   assign o_byte_err = w_last & ~w_frame_good;

   // Two-flop synchronizers; reset to 1 so an idle bus shows no edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
         r_data_sync <= {r_data_sync[0], i_ps2_data};
         r_clk_prev  <= r_clk_sync[1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bit_cnt <= 4'd0;
         r_shift   <= 9'd0;
         r_wdog    <= '0;
      end else if (w_fall) begin
         r_wdog <= '0;
         if (r_bit_cnt == 4'd0) begin
            // A start bit that reads 1 is noise; stay waiting for a real start.
            if (!w_data) begin
               r_bit_cnt <= 4'd1;
            end
         end else if (r_bit_cnt == 4'd10) begin
            r_bit_cnt <= 4'd0;
         end else begin
            // LSB arrives first, so shift in at the top.
            r_shift   <= {w_data, r_shift[8:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
      end else if (r_bit_cnt == 4'd0) begin
         r_wdog <= '0;
      end else if (r_wdog == C_WDOG_LIMIT) begin
         // Stalled mid-frame: silently drop the partial frame.
         r_bit_cnt <= 4'd0;
         r_wdog    <= '0;
      end else begin
         r_wdog <= r_wdog + C_WDOG_ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_decoder
//  Description : PS/2 keyboard scan-code decoder. Receives frames through
//                ps2_frame_rx and tracks E0 (extended) / F0 (break) prefixes,
//                emitting one event per non-prefix byte.
//  Ports       : clk, reset  - system clock, synchronous active-high reset
//                ps2_clk     - raw keyboard clock
//                ps2_data    - raw keyboard data
//                valid       - one-cycle pulse: new event on outputs
//                makeBreak   - 1 = make (press), 0 = break (release)
//                outCode     - scan code with prefixes stripped
//                extended    - 1 = event carried the E0 prefix
//                frame_err   - one-cycle pulse on parity/stop error
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_scan_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       valid,
   output logic       makeBreak,
   output logic [7:0] outCode,
   output logic       extended,
   output logic       frame_err
);

   logic [7:0] w_rx_byte;
   logic       w_rx_ok;
   logic       w_rx_err;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk        (clk),
      .reset      (reset),
      .i_ps2_clk  (ps2_clk),
      .i_ps2_data (ps2_data),
      .o_byte     (w_rx_byte),
      .o_byte_ok  (w_rx_ok),
      .o_byte_err (w_rx_err)
   );

   ps2_state_t r_state, w_state_nxt;
   logic       r_valid, w_valid_nxt;
   logic       r_make, w_make_nxt;
   logic [7:0] r_code, w_code_nxt;
   logic       r_ext, w_ext_nxt;
   logic       r_err, w_err_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_make  <= 1'b0;
         r_code  <= 8'h00;
         r_ext   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_valid_nxt;
         r_make  <= w_make_nxt;
         r_code  <= w_code_nxt;
         r_ext   <= w_ext_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_make_nxt  = r_make;
      w_code_nxt  = r_code;
      w_ext_nxt   = r_ext;

      if (w_rx_err) begin
         // A corrupted byte may have been a prefix, so forget any pending one.
         w_err_nxt   = 1'b1;
         w_state_nxt = IDLE;
      end else if (w_rx_ok) begin
         if (w_rx_byte == PS2_PREFIX_EXT) begin
            w_state_nxt = GOT_E0;
         end else if (w_rx_byte == PS2_PREFIX_BRK) begin
            unique case (r_state)
               IDLE:     w_state_nxt = GOT_F0;
               GOT_F0:   w_state_nxt = GOT_F0;
               GOT_E0:   w_state_nxt = GOT_E0F0;
               GOT_E0F0: w_state_nxt = GOT_E0F0;
               default:  w_state_nxt = IDLE;
            endcase
         end else begin
            w_valid_nxt = 1'b1;
            w_code_nxt  = w_rx_byte;
            w_make_nxt  = !((r_state == GOT_F0) || (r_state == GOT_E0F0));
            w_ext_nxt   = (r_state == GOT_E0) || (r_state == GOT_E0F0);
            w_state_nxt = IDLE;
         end
      end
   end

   assign valid     = r_valid;
   assign makeBreak = r_make;
   assign outCode   = r_code;
   assign extended  = r_ext;
   assign frame_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scan_decoder
//  Description : Directed self-checking bench for ps2_scan_decoder. Drives
//                bit-level PS/2 frames and compares decoded events against
//                hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_scan_decoder;

   localparam int C_TIMEOUT = 200;
   localparam int C_HALF    = 20;
   localparam int C_GAP     = 60;

   logic       clk;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic       valid;
   logic       makeBreak;
   logic [7:0] outCode;
   logic       extended;
   logic       frame_err;

   int n_cmp = 0;
   int n_mis = 0;

   int valid_cnt  = 0;
   int err_cnt    = 0;
   int dbl_valid  = 0;
   int dbl_err    = 0;
   int both_high  = 0;
   int lat_v      = 0;
   int lat_e      = 0;
   logic prev_valid = 1'b0;
   logic prev_err   = 1'b0;

   ps2_scan_decoder #(
      .TIMEOUT_CYCLES (C_TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .valid     (valid),
      .makeBreak (makeBreak),
      .outCode   (outCode),
      .extended  (extended),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor: counts events and flags pulses longer than one cycle.
   always @(negedge clk) begin
      if (valid) valid_cnt = valid_cnt + 1;
      if (frame_err) err_cnt = err_cnt + 1;
      if (valid && prev_valid) dbl_valid = dbl_valid + 1;
      if (frame_err && prev_err) dbl_err = dbl_err + 1;
      if (valid && frame_err) both_high = both_high + 1;
      prev_valid = valid;
      prev_err   = frame_err;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_mis = n_mis + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends the first nbits bits of a frame. On the stop-bit falling edge the
   // number of valid / frame_err pulses seen within 4 clk cycles is recorded.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
      logic [10:0] f;
      int v0, e0;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         wait_cyc(C_HALF);
         ps2_clk = 1'b0;
         if (i == 10) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            repeat (4) @(posedge clk);
            #1;
            lat_v = valid_cnt - v0;
            lat_e = err_cnt - e0;
            wait_cyc(C_HALF - 4);
         end else begin
            wait_cyc(C_HALF);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cyc(C_GAP);
   endtask

   task automatic chk_event(input string tag, input logic mb, input logic [7:0] code, input logic ext);
      chk({tag, "_make"}, {31'd0, makeBreak}, {31'd0, mb});
      chk({tag, "_code"}, {24'd0, outCode}, {24'd0, code});
      chk({tag, "_ext"},  {31'd0, extended},  {31'd0, ext});
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'd0, valid},     32'd0);
      chk({tag, "_make"},  {31'd0, makeBreak}, 32'd0);
      chk({tag, "_code"},  {24'd0, outCode},   32'd0);
      chk({tag, "_ext"},   {31'd0, extended},  32'd0);
      chk({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
   endtask

   int v_base, e_base;

   initial begin
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(5);
      chk_reset_outputs("rst");
      reset = 1'b0;
      wait_cyc(5);

      // Plain make of 1C, with latency check on the stop bit.
      v_base = valid_cnt; e_base = err_cnt;
      send_frame(8'h1C, 1'b0, 11);
      chk("make1C_lat", lat_v, 1);
      chk("make1C_cnt", valid_cnt - v_base, 1);
      chk_event("make1C", 1'b1, 8'h1C, 1'b0);

      // Break of 1C: F0 alone must not produce an event.
      v_base = valid_cnt;
      send_frame(8'hF0, 1'b0, 11);
      chk("brk1C_pfx_cnt", valid_cnt - v_base, 0);
      send_frame(8'h1C, 1'b0, 11);
      chk("brk1C_cnt", valid_cnt - v_base, 1);
      chk_event("brk1C", 1'b0, 8'h1C, 1'b0);

      // Extended break E0 F0 75, then extended make E0 75.
      v_base = valid_cnt;
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'hF0, 1'b0, 11);
      chk("ebrk75_pfx_cnt", valid_cnt - v_base, 0);
      send_frame(8'h75, 1'b0, 11);
      chk("ebrk75_cnt", valid_cnt - v_base, 1);
      chk_event("ebrk75", 1'b0, 8'h75, 1'b1);
      v_base = valid_cnt;
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'h75, 1'b0, 11);
      chk("emk75_cnt", valid_cnt - v_base, 1);
      chk_event("emk75", 1'b1, 8'h75, 1'b1);

      // Bad parity: error pulse, no event, outputs hold.
      v_base = valid_cnt; e_base = err_cnt;
      send_frame(8'h29, 1'b1, 11);
      chk("bad29_lat_err", lat_e, 1);
      chk("bad29_err_cnt", err_cnt - e_base, 1);
      chk("bad29_valid_cnt", valid_cnt - v_base, 0);
      chk_event("bad29_hold", 1'b1, 8'h75, 1'b1);

      // Bad frame cancels a pending F0.
      v_base = valid_cnt; e_base = err_cnt;
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h29, 1'b1, 11);
      send_frame(8'h29, 1'b0, 11);
      chk("pfxcancel_err_cnt", err_cnt - e_base, 1);
      chk("pfxcancel_valid_cnt", valid_cnt - v_base, 1);
      chk_event("pfxcancel", 1'b1, 8'h29, 1'b0);

      // Watchdog: F0, 5 stray bits, long idle, then 29 -> break of 29.
      v_base = valid_cnt; e_base = err_cnt;
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h5A, 1'b0, 5);
      wait_cyc(2 * C_TIMEOUT);
      send_frame(8'h29, 1'b0, 11);
      chk("wdog_err_cnt", err_cnt - e_base, 0);
      chk("wdog_valid_cnt", valid_cnt - v_base, 1);
      chk_event("wdog", 1'b0, 8'h29, 1'b0);

      // Reset in the middle of a frame, then a clean frame.
      send_frame(8'h3B, 1'b0, 6);
      reset = 1'b1;
      wait_cyc(3);
      chk_reset_outputs("midrst");
      reset = 1'b0;
      wait_cyc(5);
      v_base = valid_cnt; e_base = err_cnt;
      send_frame(8'h1C, 1'b0, 11);
      chk("postrst_cnt", valid_cnt - v_base, 1);
      chk("postrst_err_cnt", err_cnt - e_base, 0);
      chk_event("postrst", 1'b1, 8'h1C, 1'b0);

      chk("valid_width", dbl_valid, 0);
      chk("ferr_width", dbl_err, 0);
      chk("valid_ferr_overlap", both_high, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
